// File: rtl/byte_load_sequencer.sv
// byte_load_sequencer: turns one byte or 16-bit word load/store request into
// one or two accesses on a byte-wide memory. Words are big-endian: the high
// byte lives at the even address. Misaligned word requests are rejected
// with a one-cycle err pulse and never touch memory.
module byte_load_sequencer (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic        size,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Request stage: fields latched when a request is accepted, so later
  // changes on the request inputs cannot disturb the access in flight.
  logic [15:0] addr_p0;
  logic [15:0] wdata_p0;
  logic        we_p0;
  logic        size_p0;

  // Capture stage: high byte of a word load, read back during B1.
  logic [7:0]  hi_p1;

  logic        accept;
  logic        misalign;

  // Assemble a load result: word loads are big-endian, byte loads are
  // zero-extended.
  function automatic logic [15:0] load_result(input logic       word,
                                              input logic [7:0] hi,
                                              input logic [7:0] lo);
    if (word)
      return {hi, lo};
    else
      return {8'h00, lo};
  endfunction

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode and memory-side outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    accept    = 1'b0;
    misalign  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    case (state)
      IDLE: begin
        if (req) begin
          if (size && addr[0]) begin
            misalign = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = B0;
          end
        end
      end
      B0: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_we    = we_p0;
        mem_addr  = addr_p0;
        mem_wdata = size_p0 ? wdata_p0[15:8] : wdata_p0[7:0];
        state_nxt = size_p0 ? B1 : FIN;
      end
      B1: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_we    = we_p0;
        mem_addr  = addr_p0 | 16'h0001;
        mem_wdata = wdata_p0[7:0];
        state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latch the request fields on acceptance.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_p0  <= addr;
      wdata_p0 <= wdata;
      we_p0    <= we;
      size_p0  <= size;
    end
  end

  // Capture the high byte of a word load; its read data arrives in B1.
  always_ff @(posedge CLK) begin
    if (state == B1 && !we_p0)
      hi_p1 <= mem_rdata;
  end

  // Completion, error pulse and load result; reset aborts without done.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= 16'h0000;
    end else begin
      done <= (state == FIN);
      err  <= misalign;
      if (state == FIN && !we_p0)
        rdata <= load_result(size_p0, hi_p1, mem_rdata);
    end
  end

endmodule

// File: tb/tb_byte_load_sequencer.sv
// Bench for byte_load_sequencer: directed scenarios plus randomized traffic,
// checked against a byte-array memory model with big-endian word rules.
module tb_byte_load_sequencer;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req;
  logic        we;
  logic        size;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] exp_rdata;

  byte_load_sequencer dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .req       (req),
    .we        (we),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Byte memory attached to the DUT: read data one cycle after the access.
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we)
        mem[mem_addr] <= mem_wdata;
      else
        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One access from issue to completion (or 5 cycles for a rejected one).
  // Returns in the done cycle, so the caller may issue back-to-back.
  task automatic run_access(input logic w, input logic s, input logic [15:0] a,
                            input logic [15:0] d, input bit hold_req,
                            input string nm);
    logic        aligned;
    int          lat;
    int          nacc;
    int          k;
    int          ncyc;
    logic [15:0] e_addr [2];
    logic [7:0]  e_wd   [2];
    logic [15:0] word_addr_lo;
    aligned      = !(s && a[0]);
    lat          = aligned ? (s ? 4 : 3) : 0;
    nacc         = aligned ? (s ? 2 : 1) : 0;
    ncyc         = aligned ? lat : 5;
    word_addr_lo = {a[15:1], 1'b1};
    // Byte image of the transfer in address order (big-endian for words).
    e_addr[0] = a;
    e_wd[0]   = s ? d[15:8] : d[7:0];
    e_addr[1] = word_addr_lo;
    e_wd[1]   = d[7:0];
    if (aligned) begin
      if (w) begin
        for (int i = 0; i < nacc; i++) ref_mem[e_addr[i]] = e_wd[i];
      end else if (s) begin
        exp_rdata = {ref_mem[a], ref_mem[word_addr_lo]};
      end else begin
        exp_rdata = {8'h00, ref_mem[a]};
      end
    end
    req   = 1'b1;
    we    = w;
    size  = s;
    addr  = a;
    wdata = d;
    k     = 0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      step();
      req   = hold_req && (cyc < lat);
      we    = 1'($urandom);
      size  = 1'($urandom);
      addr  = 16'($urandom);
      wdata = 16'($urandom);
      n_cmp++;
      if (busy !== (aligned && cyc < lat)) begin
        n_fail++;
        $display("FAIL %s busy c%0d: got %0b want %0b", nm, cyc, busy, aligned && cyc < lat);
      end
      n_cmp++;
      if (done !== (aligned && cyc == lat)) begin
        n_fail++;
        $display("FAIL %s done c%0d: got %0b want %0b", nm, cyc, done, aligned && cyc == lat);
      end
      n_cmp++;
      if (err !== (!aligned && cyc == 1)) begin
        n_fail++;
        $display("FAIL %s err c%0d: got %0b want %0b", nm, cyc, err, !aligned && cyc == 1);
      end
      if (mem_en) begin
        n_cmp++;
        if (k >= nacc || cyc != k + 1) begin
          n_fail++;
          $display("FAIL %s unexpected access c%0d: got access #%0d want %0d accesses", nm, cyc, k, nacc);
        end else if (mem_we !== w || mem_addr !== e_addr[k] || mem_wdata !== e_wd[k]) begin
          n_fail++;
          $display("FAIL %s access%0d: got we=%0b a=%h d=%h want we=%0b a=%h d=%h",
                   nm, k, mem_we, mem_addr, mem_wdata, w, e_addr[k], e_wd[k]);
        end
        k++;
      end else begin
        n_cmp++;
        if (mem_we !== 1'b0 || mem_addr !== 16'h0000 || mem_wdata !== 8'h00) begin
          n_fail++;
          $display("FAIL %s idle_bus c%0d: got we=%0b a=%h d=%h want zeros", nm, cyc, mem_we, mem_addr, mem_wdata);
        end
      end
    end
    n_cmp++;
    if (k != nacc) begin
      n_fail++;
      $display("FAIL %s access_count: got %0d want %0d", nm, k, nacc);
    end
    n_cmp++;
    if (rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL %s rdata: got %h want %h", nm, rdata, exp_rdata);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    req   = 1'b1;
    we    = 1'b0;
    size  = 1'b0;
    addr  = 16'h0010;
    wdata = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rdata !== 16'h0000 || mem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: got busy=%0b done=%0b err=%0b rdata=%h en=%0b want all 0",
                 busy, done, err, rdata, mem_en);
      end
    end
    req   = 1'b0;
    Reset = 1'b0;
    exp_rdata = 16'h0000;
    step();
  endtask

  task automatic test_byte_load();
    mem[16'h0041] = 8'hA5;
    ref_mem[16'h0041] = 8'hA5;
    run_access(1'b0, 1'b0, 16'h0041, 16'($urandom), 1'b0, "byte_load");
    n_cmp++;
    if (rdata !== 16'h00A5) begin
      n_fail++;
      $display("FAIL byte_load_value: got %h want 00a5", rdata);
    end
    step();
  endtask

  task automatic test_word_load();
    mem[16'h0100] = 8'h12;
    mem[16'h0101] = 8'h34;
    ref_mem[16'h0100] = 8'h12;
    ref_mem[16'h0101] = 8'h34;
    run_access(1'b0, 1'b1, 16'h0100, 16'($urandom), 1'b0, "word_load");
    n_cmp++;
    if (rdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL word_load_value: got %h want 1234", rdata);
    end
    step();
  endtask

  task automatic test_word_store();
    run_access(1'b1, 1'b1, 16'h0200, 16'hBEEF, 1'b0, "word_store");
    step();
    n_cmp++;
    if (mem[16'h0200] !== 8'hBE || mem[16'h0201] !== 8'hEF || rdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL word_store_result: got mem=%h%h rdata=%h want beef rdata 1234",
               mem[16'h0200], mem[16'h0201], rdata);
    end
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 1'b1, 16'h0003, 16'($urandom), 1'b0, "misaligned");
    step();
  endtask

  task automatic test_reset_mid();
    mem[16'h0300] = 8'h5A;
    mem[16'h0301] = 8'hC3;
    ref_mem[16'h0300] = 8'h5A;
    ref_mem[16'h0301] = 8'hC3;
    run_access(1'b0, 1'b1, 16'h0300, 16'h0000, 1'b0, "pre_reset_load");
    step();
    req  = 1'b1;
    we   = 1'b0;
    size = 1'b1;
    addr = 16'h0100;
    step();
    req = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    exp_rdata = 16'h0000;
    n_cmp++;
    if (busy !== 1'b0 || mem_en !== 1'b0 || rdata !== 16'h0000 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%0b en=%0b rdata=%h done=%0b want 0 0 0000 0",
               busy, mem_en, rdata, done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (done !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_after c%0d: got done=%0b en=%0b busy=%0b want 0", i, done, mem_en, busy);
      end
    end
  endtask

  task automatic test_req_held();
    run_access(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b1, "req_held");
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (mem_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL req_held_extra c%0d: got en=%0b busy=%0b done=%0b want 0", i, mem_en, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    a = 16'($urandom) & 16'hFFFE;
    run_access(1'b0, 1'b1, a, 16'($urandom), 1'b0, "b2b_first");
    run_access(1'b0, 1'b0, 16'hFFFF, 16'($urandom), 1'b0, "b2b_ffff");
    run_access(1'b1, 1'b0, 16'hFFFF, 16'($urandom), 1'b0, "b2b_store_ffff");
    run_access(1'b0, 1'b0, 16'hFFFF, 16'($urandom), 1'b0, "b2b_reload_ffff");
    step();
  endtask

  task automatic test_random();
    logic        w;
    logic        s;
    logic [15:0] a;
    int          gap;
    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom);
      s = 1'($urandom);
      // Concentrate addresses so loads often revisit stored bytes.
      a = {12'h0F0, 4'($urandom)};
      if (n % 7 == 0) a = 16'($urandom);
      run_access(w, s, a, 16'($urandom), 1'b0, "random");
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
    end
  endtask

  initial begin
    Reset     = 1'b1;
    req       = 1'b0;
    we        = 1'b0;
    size      = 1'b0;
    addr      = 16'h0000;
    wdata     = 16'h0000;
    exp_rdata = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_byte_load();
    test_word_load();
    test_word_store();
    test_misaligned();
    test_reset_mid();
    test_req_held();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
